// File: rtl/pixel_gen_pipe.sv
// pixel_gen_pipe: two-stage pipelined Pong pixel generator drawing header, walls, paddles and balls,
// with per-paddle hit-flash FSMs timed in frames.
module pixel_gen_pipe #(
    parameter int          NUM_BALLS       = 2,
    parameter int          TOP_MARGIN      = 25,
    parameter int          WALL_W          = 32,
    parameter int          SCREEN_W        = 640,
    parameter int          PADDLE_W        = 8,
    parameter int          PADDLE_H        = 72,
    parameter int          FLASH_FRAMES    = 8,
    parameter logic [11:0] WALL_COLOR      = 12'h89C,
    parameter logic [11:0] PADDLE_COLOR    = 12'h24F,
    parameter logic [11:0] FLASH_COLOR     = 12'hFF0,
    parameter logic [11:0] HEADER_BG_COLOR = 12'h135
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [9:0]              x,
    input  logic [9:0]              y,
    input  logic                    video_on,
    input  logic                    frame_tick,
    input  logic [10*NUM_BALLS-1:0] ball_x,
    input  logic [10*NUM_BALLS-1:0] ball_y,
    input  logic [4*NUM_BALLS-1:0]  ball_speed,
    input  logic [NUM_BALLS-1:0]    ball_en,
    input  logic [9:0]              paddle1_y,
    input  logic [9:0]              paddle2_y,
    input  logic                    hit1,
    input  logic                    hit2,
    input  logic [11:0]             bg_pixel,
    input  logic [11:0]             game_over_pixel,
    input  logic                    game_over,
    input  logic                    text_on,
    input  logic [11:0]             text_rgb,
    output logic [11:0]             rgb
);
    localparam logic [10:0] TM = 11'(TOP_MARGIN);
    localparam logic [10:0] PH = 11'(PADDLE_H);
    localparam logic [10:0] PW = 11'(PADDLE_W);
    localparam logic [10:0] WL = 11'(WALL_W);
    localparam logic [10:0] WR = 11'(SCREEN_W - WALL_W);
    localparam logic [3:0]  FF = 4'(FLASH_FRAMES);

    typedef enum logic {IDLE, FLASH} fl_t;

    // 11-bit copies so bx+7 and paddle bottom never wrap
    logic [10:0] xe, ye, p1t, p2t, bx, by;
    logic [2:0]  c, r;
    logic [3:0]  sp;
    logic [7:0]  row;
    logic        hdr_c, wall_c, lp_c, rp_c, bh_c;
    logic [11:0] bc_c;

    assign xe  = {1'b0, x};
    assign ye  = {1'b0, y};
    assign p1t = {1'b0, paddle1_y} + TM;
    assign p2t = {1'b0, paddle2_y} + TM;

    always_comb begin
        hdr_c  = ye < TM;
        wall_c = xe < WL || xe > WR;
        lp_c   = xe >= WL && xe <= WL + PW && ye >= p1t && ye <= p1t + PH;
        rp_c   = xe >= WR - PW && xe <= WR && ye >= p2t && ye <= p2t + PH;
    end

    // Walk from highest index down so the lowest-index ball overwrites last and wins
    always_comb begin
        bh_c = 1'b0;
        bc_c = 12'hFFF;
        bx   = '0;
        by   = '0;
        c    = '0;
        r    = '0;
        sp   = '0;
        row  = '0;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            bx  = {1'b0, ball_x[10*i +: 10]};
            by  = {1'b0, ball_y[10*i +: 10]};
            sp  = ball_speed[4*i +: 4];
            c   = xe[2:0] - bx[2:0];
            r   = ye[2:0] - by[2:0];
            row = (r == 3'd0 || r == 3'd7) ? 8'b00111100 :
                  (r == 3'd1 || r == 3'd6) ? 8'b01111110 : 8'hFF;
            if (ball_en[i] && xe >= bx && xe <= bx + 11'd7 && ye >= by && ye <= by + 11'd7 && row[c]) begin
                bh_c = 1'b1;
                bc_c = sp == 4'd3 ? 12'h00F : sp == 4'd4 ? 12'h0F0 : sp == 4'd5 ? 12'hF00 : 12'hFFF;
            end
        end
    end

    logic        v1, go1, hdr1, wall1, lp1, rp1, bh1;
    logic [11:0] hc1, bc1, gop1, bg1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            go1   <= 1'b0;
            hdr1  <= 1'b0;
            wall1 <= 1'b0;
            lp1   <= 1'b0;
            rp1   <= 1'b0;
            bh1   <= 1'b0;
            hc1   <= '0;
            bc1   <= '0;
            gop1  <= '0;
            bg1   <= '0;
        end else begin
            v1    <= video_on;
            go1   <= game_over;
            hdr1  <= hdr_c;
            wall1 <= wall_c;
            lp1   <= lp_c;
            rp1   <= rp_c;
            bh1   <= bh_c;
            hc1   <= text_on ? text_rgb : HEADER_BG_COLOR;
            bc1   <= bc_c;
            gop1  <= game_over_pixel;
            bg1   <= bg_pixel;
        end
    end

    logic [1:0]  hit;
    logic [11:0] pad_col [2];

    assign hit = {hit2, hit1};

    for (genvar g = 0; g < 2; g++) begin : flash
        fl_t        st, st_n;
        logic [3:0] cnt, cnt_n;
        always_comb begin
            st_n  = game_over ? IDLE : hit[g] ? FLASH :
                    (st == FLASH && frame_tick && cnt == 4'd1) ? IDLE : st;
            cnt_n = game_over ? 4'd0 : hit[g] ? FF :
                    (st == FLASH && frame_tick) ? cnt - 4'd1 : cnt;
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st  <= IDLE;
                cnt <= 4'd0;
            end else begin
                st  <= st_n;
                cnt <= cnt_n;
            end
        end
        // Odd counts blink, so the paddle alternates colour every frame
        assign pad_col[g] = (st == FLASH && cnt[0]) ? FLASH_COLOR : PADDLE_COLOR;
    end

    logic [11:0] rgb_n;

    always_comb begin
        rgb_n = !v1   ? 12'h000 :
                go1   ? gop1 :
                hdr1  ? hc1 :
                wall1 ? WALL_COLOR :
                lp1   ? pad_col[0] :
                rp1   ? pad_col[1] :
                bh1   ? bc1 : bg1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rgb <= 12'h000;
        else        rgb <= rgb_n;
    end
endmodule

// File: tb/tb_pixel_gen_pipe.sv
// tb_pixel_gen_pipe: scoreboard bench; a frame-level reference model predicts every pixel and a
// monitor compares rgb exactly two clocks after each pixel enters.
module tb_pixel_gen_pipe;
    localparam int NB = 2, TM = 25, WW = 32, SW = 640, PW = 8, PH = 72, FFR = 8;

    logic        clk = 1'b0, rst_n;
    logic [9:0]  x, y, paddle1_y, paddle2_y;
    logic        video_on, frame_tick, hit1, hit2, game_over, text_on;
    logic [19:0] ball_x, ball_y;
    logic [7:0]  ball_speed;
    logic [1:0]  ball_en;
    logic [11:0] bg_pixel, game_over_pixel, text_rgb, rgb;

    pixel_gen_pipe dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .video_on(video_on), .frame_tick(frame_tick),
        .ball_x(ball_x), .ball_y(ball_y), .ball_speed(ball_speed), .ball_en(ball_en),
        .paddle1_y(paddle1_y), .paddle2_y(paddle2_y), .hit1(hit1), .hit2(hit2),
        .bg_pixel(bg_pixel), .game_over_pixel(game_over_pixel), .game_over(game_over),
        .text_on(text_on), .text_rgb(text_rgb), .rgb(rgb)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [11:0] exp;
        string       tag;
    } ent_t;

    ent_t q[$];
    int   cyc = 0, errors = 0, checks = 0;
    int   m_cnt [2];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            ent_t e;
            e = q.pop_front();
            checks++;
            if (e.due != cyc || rgb !== e.exp) begin
                errors++;
                $display("FAIL %s: rgb=%h expected=%h (due cycle %0d, now %0d)", e.tag, rgb, e.exp, e.due, cyc);
            end
        end
    end

    function automatic int mn(int a, int b);
        return a < b ? a : b;
    endfunction

    function automatic logic [11:0] scol(int s);
        return s == 3 ? 12'h00F : s == 4 ? 12'h0F0 : s == 5 ? 12'hF00 : 12'hFFF;
    endfunction

    function automatic logic [11:0] pcol(int p);
        return (m_cnt[p] % 2 == 1) ? 12'hFF0 : 12'h24F;
    endfunction

    function automatic logic [11:0] model();
        int xi, yi, p1, p2, dx, dy;
        xi = int'(x);
        yi = int'(y);
        p1 = int'(paddle1_y) + TM;
        p2 = int'(paddle2_y) + TM;
        if (!video_on) return 12'h000;
        if (game_over) return game_over_pixel;
        if (yi < TM) return text_on ? text_rgb : 12'h135;
        if (xi < WW || xi > SW - WW) return 12'h89C;
        if (xi >= WW && xi <= WW + PW && yi >= p1 && yi <= p1 + PH) return pcol(0);
        if (xi >= SW - WW - PW && xi <= SW - WW && yi >= p2 && yi <= p2 + PH) return pcol(1);
        for (int i = 0; i < NB; i++) begin
            dx = xi - int'(ball_x[10*i +: 10]);
            dy = yi - int'(ball_y[10*i +: 10]);
            if (ball_en[i] && dx >= 0 && dx <= 7 && dy >= 0 && dy <= 7 && mn(dx, 7 - dx) + mn(dy, 7 - dy) >= 2)
                return scol(int'(ball_speed[4*i +: 4]));
        end
        return bg_pixel;
    endfunction

    // Frames-left counter per paddle: zero means idle, odd means flash colour
    task automatic step(input int want = -1, input string t = "pix");
        ent_t e;
        logic [1:0] h;
        bg_pixel        = 12'($urandom);
        game_over_pixel = 12'($urandom);
        h = {hit2, hit1};
        for (int p = 0; p < 2; p++)
            m_cnt[p] = !rst_n || game_over ? 0 : h[p] ? FFR : (frame_tick && m_cnt[p] > 0) ? m_cnt[p] - 1 : m_cnt[p];
        e.due = cyc + 2;
        e.exp = !rst_n ? 12'h000 : want >= 0 ? 12'(want) : model();
        e.tag = t;
        q.push_back(e);
        @(negedge clk);
        hit1 = 1'b0;
        hit2 = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic px(input int xx, input int yy, input int want = -1, input string t = "pix");
        x = 10'(xx);
        y = 10'(yy);
        step(want, t);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        foreach (q[i]) q[i].exp = 12'h000;
        m_cnt = '{0, 0};
        @(negedge clk);
        repeat (n) step(-1, "midreset");
        rst_n = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        m_cnt = '{0, 0};
        rst_n = 1'b0; video_on = 1'b1; frame_tick = 1'b0; hit1 = 1'b0; hit2 = 1'b0;
        game_over = 1'b0; text_on = 1'b0; text_rgb = 12'hABC;
        paddle1_y = 10'd0; paddle2_y = 10'd200;
        ball_x = {10'd203, 10'd200}; ball_y = {10'd100, 10'd100};
        ball_speed = {4'd5, 4'd4}; ball_en = 2'b11;
        x = 10'd204; y = 10'd102; bg_pixel = '0; game_over_pixel = '0;
        @(negedge clk);
        repeat (4) px(204, 102, -1, "reset_hold");
        rst_n = 1'b1;
        px(204, 102, 12'h0F0, "reset_first_pixel");
        px(200, 100, -1, "ball_corner_bg");
        px(209, 102, 12'hF00, "ball1_body");
        ball_en = 2'b01;
        px(209, 102, -1, "ball1_disabled_bg");
        ball_en = 2'b11;
        px(205, 100, 12'h0F0, "ball_overlap_lowest");
        ball_x = {10'd500, 10'd1020};
        ball_en = 2'b01;
        px(2, 102, 12'h89C, "wrap_guard_wall");
        ball_en = 2'b00;
        px(35, 25, 12'h24F, "paddle_top");
        px(35, 97, 12'h24F, "paddle_bottom");
        px(35, 98, -1, "paddle_below_bg");
        px(40, 50, 12'h24F, "paddle_right_edge");
        px(41, 50, -1, "paddle_past_edge_bg");
        px(31, 50, 12'h89C, "left_wall");
        px(609, 50, 12'h89C, "right_wall");
        px(604, 250, 12'h24F, "right_paddle");
        px(300, 24, 12'h135, "header_bg");
        text_on = 1'b1;
        px(300, 24, 12'hABC, "header_text");
        text_on = 1'b0;
        video_on = 1'b0;
        px(35, 50, 12'h000, "video_off");
        video_on = 1'b1;
        hit1 = 1'b1;
        px(36, 60, 12'h24F, "flash_start");
        for (int k = 1; k <= 9; k++) begin
            frame_tick = 1'b1;
            px(300, 300, -1, "tick_bg");
            px(36, 60, (k < FFR && k % 2 == 1) ? 12'hFF0 : 12'h24F, "flash_blink");
        end
        hit1 = 1'b1;
        px(36, 60, 12'h24F, "retrig_start");
        for (int k = 1; k <= 5; k++) begin
            frame_tick = 1'b1;
            px(36, 60, k % 2 == 1 ? 12'hFF0 : 12'h24F, "retrig_count");
        end
        hit1 = 1'b1;
        frame_tick = 1'b1;
        px(36, 60, 12'h24F, "hit_and_tick_reload");
        frame_tick = 1'b1;
        px(36, 60, 12'hFF0, "after_reload_tick");
        hit2 = 1'b1;
        px(604, 250, 12'h24F, "rflash_start");
        frame_tick = 1'b1;
        px(604, 250, 12'hFF0, "rflash_blink");
        game_over = 1'b1;
        px(36, 60, -1, "game_over_image");
        game_over = 1'b0;
        px(36, 60, 12'h24F, "go_cleared_left");
        px(604, 250, 12'h24F, "go_cleared_right");
        game_over = 1'b1;
        hit1 = 1'b1;
        px(36, 60, -1, "go_hit");
        game_over = 1'b0;
        px(36, 60, 12'h24F, "go_hit_ignored");
        frame_tick = 1'b1;
        px(36, 60, 12'h24F, "go_hit_ignored_tick");

        for (int n = 0; n < 2500; n++) begin
            if (n % 16 == 0) begin
                ball_x = {10'($urandom_range(180, 220)), ($urandom_range(0, 7) == 0) ? 10'($urandom_range(1012, 1023)) : 10'($urandom_range(180, 220))};
                ball_y = {10'($urandom_range(90, 120)), 10'($urandom_range(90, 120))};
                ball_speed = 8'($urandom);
                ball_en = 2'($urandom);
            end
            if (n % 64 == 0) begin
                paddle1_y = 10'($urandom_range(0, 400));
                paddle2_y = 10'($urandom_range(0, 400));
            end
            case ($urandom_range(0, 3))
                0, 1:    begin x = 10'($urandom_range(175, 230)); y = 10'($urandom_range(85, 130)); end
                2:       begin x = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(28, 44)) : 10'($urandom_range(596, 612)); y = 10'($urandom_range(0, 500)); end
                default: begin x = 10'($urandom); y = 10'($urandom); end
            endcase
            video_on   = $urandom_range(0, 15) != 0;
            game_over  = $urandom_range(0, 63) == 0;
            text_on    = 1'($urandom);
            text_rgb   = 12'($urandom);
            hit1       = $urandom_range(0, 31) == 0;
            hit2       = $urandom_range(0, 31) == 0;
            frame_tick = $urandom_range(0, 7) == 0;
            step(-1, "random");
            if (n == 1200) do_reset(3);
        end

        video_on = 1'b0;
        repeat (3) step(-1, "drain");
        repeat (6) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d outputs never compared, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
